// File: rtl/mul_pipe.sv
// Pipelined multiplier with optional round-half-up right shift and a valid/ready handshake.
// Build option: define MUL_PIPE_SAT_EN to clamp out-of-range results and raise ovf.
module mul_pipe #(
  parameter int A_W    = 10,
  parameter int B_W    = 18,
  parameter int OUT_W  = 28,
  parameter int LAT    = 4,
  parameter int SIGNED = 0,
  parameter int SHIFT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             ovf
);

  localparam int W  = A_W + B_W;
  // Two guard bits: one for unsigned operands in signed arithmetic, one for the rounding add.
  localparam int RW = W + 2;
  localparam logic [RW-1:0] RND = (SHIFT == 0) ? '0 :
    ({{(RW-1){1'b0}}, 1'b1} << ((SHIFT == 0) ? 0 : SHIFT - 1));

  logic signed [A_W:0]    a_x;
  logic signed [B_W:0]    b_x;
  logic signed [RW-1:0]   prod;
  logic signed [RW-1:0]   sum;
  logic signed [RW-1:0]   r;
  logic [OUT_W-1:0]       res_c;
  logic                   ovf_c;
  logic                   advance;

  assign a_x  = (SIGNED != 0) ? $signed({a[A_W-1], a}) : $signed({1'b0, a});
  assign b_x  = (SIGNED != 0) ? $signed({b[B_W-1], b}) : $signed({1'b0, b});
  assign prod = RW'(a_x) * RW'(b_x);
  assign sum  = prod + $signed(RND);
  assign r    = sum >>> SHIFT;

  generate
    if (OUT_W >= RW) begin : g_ext
      assign res_c = OUT_W'(r);
      assign ovf_c = 1'b0;
    end else begin : g_red
`ifdef MUL_PIPE_SAT_EN
      localparam logic signed [RW-1:0] MAXV = (SIGNED != 0) ?
        $signed({{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}}) :
        $signed({{(RW-OUT_W){1'b0}}, {OUT_W{1'b1}}});
      localparam logic signed [RW-1:0] MINV = (SIGNED != 0) ?
        $signed({{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}}) :
        $signed({RW{1'b0}});
      always_comb begin
        res_c = r[OUT_W-1:0];
        ovf_c = 1'b0;
        if (r > MAXV) begin
          res_c = MAXV[OUT_W-1:0];
          ovf_c = 1'b1;
        end else if (r < MINV) begin
          res_c = MINV[OUT_W-1:0];
          ovf_c = 1'b1;
        end
      end
`else
      logic unused_r_hi;
      assign unused_r_hi = ^r[RW-1:OUT_W];
      assign res_c = r[OUT_W-1:0];
      assign ovf_c = 1'b0;
`endif
    end
  endgenerate

  logic [LAT-1:0]   vld;
  logic [LAT-1:0]   ovf_q;
  logic [OUT_W-1:0] res_q [LAT];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Whole pipeline moves or holds as one; a bubble enters when in_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= '0;
      ovf_q <= '0;
      for (int i = 0; i < LAT; i++) res_q[i] <= '0;
    end else if (advance) begin
      vld[0]   <= in_valid;
      res_q[0] <= res_c;
      ovf_q[0] <= ovf_c;
      for (int i = LAT - 1; i > 0; i--) begin
        vld[i]   <= vld[i-1];
        res_q[i] <= res_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign result    = res_q[LAT-1];
  assign ovf       = ovf_q[LAT-1];

endmodule
